// File: rtl/queue_port_ctrl_pkg.sv
// Shared constants and encodings for the queue port controller.
// Holds the queue geometry, mirror-level width and the q_rw pin encoding.
// No logic; imported by the interface, the skid buffer and the controller.
package queue_port_ctrl_pkg;

  localparam int WORD_W       = 4;                         // queue word length
  localparam int QUEUE_DEPTH  = 8;                         // queue capacity in words
  localparam int LEVEL_W      = $clog2(QUEUE_DEPTH + 1);   // holds 0..QUEUE_DEPTH
  localparam int RD_LATENCY   = 1;                         // pop-issue to q_dout valid
  localparam int WR_BURST_MAX = 4;                         // pushes before a forced drain

  // The queue has no idle encoding: write when 1, pop when 0.
  localparam logic Q_WRITE = 1'b1;
  localparam logic Q_READ  = 1'b0;

endpackage

// File: rtl/queue_port_ctrl_if.sv
// Bundle of the write stream, read stream and queue pin signals.
// master: the controller side; slave: producer/consumer/queue side.
// Ports: wr_valid/wr_data/wr_ready, rd_valid/rd_data, q_rw/q_din/q_empty/q_full/q_dout.
interface queue_port_ctrl_if
  import queue_port_ctrl_pkg::*;
#(
  parameter int W = WORD_W
);

  logic         wr_valid;
  logic [W-1:0] wr_data;
  logic         wr_ready;

  logic         rd_valid;
  logic [W-1:0] rd_data;

  logic         q_rw;
  logic [W-1:0] q_din;
  logic         q_empty;
  logic         q_full;
  logic [W-1:0] q_dout;

  modport master (
    input  wr_valid, wr_data, q_empty, q_full, q_dout,
    output wr_ready, rd_valid, rd_data, q_rw, q_din
  );

  modport slave (
    output wr_valid, wr_data, q_empty, q_full, q_dout,
    input  wr_ready, rd_valid, rd_data, q_rw, q_din
  );

endinterface

// File: rtl/queue_port_ctrl_skid_buf2.sv
// Two-entry valid/ready buffer for a W-bit stream.
// Latency: a word accepted on an edge is presented at out_dat from the next cycle.
// Backpressure: in_rdy is registered and drops while both entries are occupied.
// Ports: clk, reset (async, active-high), in_vld/in_dat/in_rdy, out_vld/out_dat/out_rdy.
module skid_buf2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic [1:0]   cnt_nxt;
  logic         enq;
  logic         deq;

  assign enq     = in_vld & in_rdy;
  assign deq     = out_rdy & out_vld;
  assign cnt_nxt = cnt + {1'b0, enq} - {1'b0, deq};

  assign out_vld = (cnt != 2'd0);
  assign out_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      in_rdy <= 1'b0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt    <= cnt_nxt;
      // Ready reflects the occupancy after this edge, so it never overfills.
      in_rdy <= (cnt_nxt < 2'd2);
    end
  end

endmodule

// File: rtl/queue_port_ctrl.sv
// Owns the queue's single rw pin: pushes from a write stream, pops into a read stream.
// Latency: accepted word pushed next cycle at earliest; pop returns rd_valid RD_LAT+1 cycles later.
// Backpressure: wr_ready from the 2-entry skid buffer; the read stream cannot stall.
// Ports: clk, reset (async, active-high), bus (write/read streams + queue pins),
//        level (mirror occupancy), err (sticky mirror/flag disagreement).
module queue_port_ctrl
  import queue_port_ctrl_pkg::*;
#(
  parameter int W        = WORD_W,
  parameter int QDEPTH   = QUEUE_DEPTH,
  parameter int RD_LAT   = RD_LATENCY,
  parameter int WR_BURST = WR_BURST_MAX
) (
  input  logic               clk,
  input  logic               reset,
  queue_port_ctrl_if.master  bus,
  output logic [LEVEL_W-1:0] level,
  output logic               err
);

  localparam int BC_W = $clog2(WR_BURST + 1);

  logic              wb_vld;
  logic [W-1:0]      wb_dat;
  logic              push;
  logic              pop;
  logic              force_drain;
  logic [BC_W-1:0]   burst_cnt;
  logic [RD_LAT-1:0] pop_pipe;
  logic              armed;
  logic              lvl_empty;
  logic              lvl_full;
  logic              flag_mismatch;
  logic              sat_err;

  skid_buf2 #(
    .W (W)
  ) u_wbuf (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (bus.wr_valid),
    .in_dat  (bus.wr_data),
    .in_rdy  (bus.wr_ready),
    .out_vld (wb_vld),
    .out_dat (wb_dat),
    .out_rdy (push)
  );

  // Every cycle is either a write or a pop attempt; a pop on an empty queue is a no-op.
  assign bus.q_rw  = (wb_vld & ~bus.q_full & ~force_drain) ? Q_WRITE : Q_READ;
  assign bus.q_din = wb_dat;

  assign push = (bus.q_rw == Q_WRITE) & ~bus.q_full;
  assign pop  = (bus.q_rw == Q_READ)  & ~bus.q_empty;

  // Fairness: a run of WR_BURST pushes into a non-empty queue earns one drain cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt   <= '0;
      force_drain <= 1'b0;
    end else begin
      force_drain <= 1'b0;
      if (pop) begin
        burst_cnt <= '0;
      end else if (push && !lvl_empty) begin
        if (burst_cnt == BC_W'(WR_BURST - 1)) begin
          burst_cnt   <= '0;
          force_drain <= 1'b1;
        end else begin
          burst_cnt <= burst_cnt + BC_W'(1);
        end
      end
    end
  end

  // Pop flags travel alongside the queue's read latency; the exiting flag marks q_dout valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_pipe     <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      pop_pipe[0] <= pop;
      for (int i = 1; i < RD_LAT; i++) begin
        pop_pipe[i] <= pop_pipe[i-1];
      end
      bus.rd_valid <= pop_pipe[RD_LAT-1];
      if (pop_pipe[RD_LAT-1]) begin
        bus.rd_data <= bus.q_dout;
      end
    end
  end

  assign lvl_empty     = (level == '0);
  assign lvl_full      = (level == LEVEL_W'(QDEPTH));
  assign flag_mismatch = (lvl_empty != bus.q_empty) | (lvl_full != bus.q_full);
  assign sat_err       = (push & lvl_full) | (pop & lvl_empty);

  // Mirror count. Checking waits until the queue has been seen empty once, since its
  // pointers survive reset and any residue is only gone after the reset drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
      armed <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (bus.q_empty) begin
        armed <= 1'b1;
      end
      if (push && !lvl_full) begin
        level <= level + LEVEL_W'(1);
      end else if (pop && !lvl_empty) begin
        level <= level - LEVEL_W'(1);
      end
      if (armed && (flag_mismatch || sat_err)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/queue_port_ctrl.md
# queue_port_ctrl

Port controller that owns the single read/write pin of the 8×4 hardware queue and turns it into a valid/ready write stream and an always-accept read stream. The queue has no idle encoding: `rw=1` writes unless full, and `rw=0` pops unless empty. This block therefore decides every cycle whether to push or drain. It sits directly upstream of the queue, driving `q_rw`/`q_din`, and directly downstream of it, consuming `q_dout`/`q_empty`/`q_full`. It also keeps a mirror occupancy count for status and consistency checking.

## Interface
- `W`, 4: data word width; must match the queue word length.
- `QDEPTH`, 8: queue capacity in words.
- `RD_LAT`, 1: cycles from pop-issue cycle until `q_dout` holds the popped word.
- `WR_BURST`, 4: maximum consecutive write grants while the queue is non-empty before one drain cycle is forced.

- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `wr_valid`  in  1  producer has a word.
- `wr_data`  in  W  producer word.
- `wr_ready`  out  1  skid buffer can take a word; registered.
- `rd_valid`  out  1  one-cycle strobe: `rd_data` holds a popped word. No backpressure.
- `rd_data`  out  W  popped word; registered.
- `q_rw`  out  1  to queue `rw`: 1 = write, 0 = read/pop.
- `q_din`  out  W  to queue `din`.
- `q_empty`  in  1  queue empty flag.
- `q_full`  in  1  queue full flag.
- `q_dout`  in  W  queue read data.
- `level`  out  4  mirror occupancy, 0..QDEPTH.
- `err`  out  1  sticky: mirror count disagrees with the queue flags.

## Operation
- Write skid buffer (`wbuf`):
  - 2-entry FIFO for `W`-bit words.
  - A word is accepted on an edge where `wr_valid & wr_ready`.
  - `wr_ready = wbuf count < 2`, registered.
  - `q_din` = `wbuf` head.
- Grant, evaluated every cycle: `q_rw = wbuf_nonempty & !q_full & !force_drain`.
  - Otherwise `q_rw=0`, which pops when `q_empty=0` and is a no-op when `q_empty=1`.
- Push: on an edge with `q_rw=1 & !q_full`. The `wbuf` head is dequeued.
- Pop: on an edge with `q_rw=0 & !q_empty`.
- Fairness:
  - `burst_cnt` increments on each push edge taken while `level>0`.
  - On reaching `WR_BURST`, `force_drain=1` for exactly the next cycle, and `burst_cnt` clears.
  - Any pop clears `burst_cnt`.
- Read return:
  - A shift register of depth `RD_LAT` tracks pop flags.
  - When the flag exits, `q_dout` is captured into `rd_data` and `rd_valid` pulses.
- Mirror:
  - `level` +1 on push, −1 on pop. Both cannot occur in the same cycle.
  - Saturation at 0 or `QDEPTH` is a mirror error.
- Error:
  - Once armed, `err` sets if `(level==0) != q_empty` or `(level==QDEPTH) != q_full`.
  - `err` clears only on reset.
  - Arming happens the first cycle `q_empty=1` is seen after reset release.
- Reset requirements:
  - The queue's own pointers are not cleared by `reset`, so `reset` must be held at least QDEPTH+1 cycles.
  - During reset `q_rw=0`, which drains any residue.
  - Pops during reset are not reported and not counted.

## Timing
- Reset values:
  - `wr_ready=0` during reset, then 1 from the first edge after release.
  - `rd_valid=0`, `rd_data=0`, `q_rw=0`, `q_din=0`, `level=0`, `err=0`, `burst_cnt=0`, `wbuf` empty, pop pipeline clear, mirror unarmed.
- Write latency:
  - A word accepted at the end of cycle t can be granted in cycle t+1, and is in the queue after that edge.
- Read latency:
  - Pop issued in cycle t (`q_rw=0`, `q_empty=0`).
  - `q_dout` is valid in cycle t+RD_LAT.
  - `rd_valid=1` with that word in cycle t+RD_LAT+1, for one cycle.
- Throughput: one queue operation per cycle.
  - Sustained `wr_valid` into a non-empty queue yields WR_BURST pushes then 1 pop, repeating.
- Full queue with pending write: `q_rw=0`, so the queue pops. The write is granted the following cycle.
- Empty queue, empty `wbuf`: `q_rw=0` no-op, `rd_valid` stays 0.
- Asynchronous reset mid-operation: everything returns to reset values immediately. In-flight pop flags are discarded.

## Structure
- Shared package holds:
  - `QDEPTH`, word width, and the level width.
  - The `q_rw` encodings `Q_WRITE=1'b1` and `Q_READ=1'b0`.
- Natural sub-module: `skid_buf2`, a 2-entry valid/ready buffer, reusable on other stream inputs.
- The grant logic, fairness counter, pop pipeline and mirror live in `queue_port_ctrl`.

## Test plan
- Reset 10 cycles, then idle 5 cycles → `q_rw=0`, `level=0`, `err=0`, `rd_valid` never 1, `wr_ready=1`.
- Write 3,7,9 back-to-back, producer then idle → `level` 1,2,3 during writes, then drains. `rd_valid` pulses with `rd_data` 3,7,9 in order, each at pop cycle+2 (RD_LAT=1).
- Hold `wr_valid` with 12 words 0..B → pushes and pops interleave 4:1, `rd_data` order 0,1,2,… with no loss, `level` never exceeds 8.
- Pre-fill the queue to 8 (`q_full=1`) with a write pending → that cycle `q_rw=0` pops the oldest word, the write is granted next cycle, and `level` stays ≤8.
- Force `q_empty` low while `level=0` (fault injection) → `err=1` next cycle, and it remains 1 until reset.
- Assert `reset` asynchronously mid-burst with 2 pops in flight → `rd_valid` stays 0, `level=0` immediately, and no stale `rd_data` appears after release.
